// File: rtl/bsg_tnc_pkg.sv
// Shared field geometry for the multi-channel test-node client.
package bsg_tnc_pkg;

  localparam int id_width_gp = 4;

  function automatic int chan_width(input int num_channels);
    return (num_channels <= 2) ? 1 : $clog2(num_channels);
  endfunction

  function automatic int id_msb(input int ring_width);
    return ring_width - 1;
  endfunction

  function automatic int chan_msb(input int ring_width);
    return ring_width - 1 - id_width_gp;
  endfunction

  function automatic int payload_msb(input int payload_width);
    return payload_width - 1;
  endfunction

endpackage

// File: rtl/bsg_tnc_chan_fifo.sv
// Per-channel registered FIFO; ready_o is simply ~full, so a dequeue never
// frees a slot for an enqueue in the same cycle.
module bsg_tnc_chan_fifo #(
  parameter int width_p = 64,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  input  logic               ready_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int ptr_w_lp = (els_p <= 1) ? 1 : $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic                enq, deq;

  assign full_o  = (cnt_q == cnt_w_lp'(els_p));
  assign empty_o = (cnt_q == '0);
  assign ready_o = ~full_o;
  assign v_o     = ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign enq     = v_i & ~full_o;
  assign deq     = v_o & ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (enq) wr_ptr_d = (wr_ptr_q == ptr_w_lp'(els_p - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (deq) rd_ptr_d = (rd_ptr_q == ptr_w_lp'(els_p - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (enq & ~deq)      cnt_d = cnt_q + 1'b1;
    else if (~enq & deq) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bsg_test_node_client_mc.sv
// Multi-channel bsg test-ring client: ring packets fan out to per-core FIFOs,
// core results are round-robin merged back. Optional counters: BSG_TNC_MC_STATS_EN.
module bsg_test_node_client_mc
  import bsg_tnc_pkg::*;
#(
  parameter int ring_width_p    = 80,
  parameter int payload_width_p = 64,
  parameter int num_channels_p  = 2,
  parameter int fifo_depth_p    = 2,
  parameter int client_id_p     = 0
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
  input  logic                                      en_i,
  input  logic                                      v_i,
  input  logic [ring_width_p-1:0]                   data_i,
  output logic                                      ready_o,
  output logic                                      v_o,
  output logic [ring_width_p-1:0]                   data_o,
  input  logic                                      yumi_i,
  output logic [num_channels_p-1:0]                 core_v_o,
  output logic [num_channels_p*payload_width_p-1:0] core_data_o,
  input  logic [num_channels_p-1:0]                 core_ready_i,
  input  logic [num_channels_p-1:0]                 core_v_i,
  input  logic [num_channels_p*payload_width_p-1:0] core_data_i,
`ifdef BSG_TNC_MC_STATS_EN
  output logic [31:0]                               stat_in_o,
  output logic [31:0]                               stat_out_o,
  output logic [15:0]                               stat_drop_o,
`endif
  output logic [num_channels_p-1:0]                 core_yumi_o
);

  localparam int cw_lp       = chan_width(num_channels_p);
  localparam int id_msb_lp   = id_msb(ring_width_p);
  localparam int chan_msb_lp = chan_msb(ring_width_p);
  localparam int pay_msb_lp  = payload_msb(payload_width_p);

  typedef logic [cw_lp-1:0] chan_t;

  logic                       in_v_q, in_v_d, out_v_q, out_v_d;
  logic [ring_width_p-1:0]    in_data_q, in_data_d, out_data_q, out_data_d;
  chan_t                      last_q, last_d, in_chan, grant_idx;
  logic [payload_width_p-1:0] in_pay;
  logic [num_channels_p-1:0]  fifo_v, fifo_rdy, fifo_full, fifo_empty;
  logic                       in_range, tgt_rdy, dispatch, drop, loadable, grant_v, gnt;
  logic [ring_width_p-1:0]    out_pkt;
  int                         grant_j;

  assign in_chan  = in_data_q[chan_msb_lp -: cw_lp];
  assign in_pay   = in_data_q[pay_msb_lp:0];
  assign in_range = int'(in_chan) < num_channels_p;
  assign dispatch = in_v_q & (~in_range | tgt_rdy);
  assign drop     = in_v_q & ~in_range;
  assign ready_o  = reset_n_i & en_i & (~in_v_q | dispatch);
  assign loadable = ~out_v_q | yumi_i;
  assign gnt      = reset_n_i & loadable & grant_v;
  assign v_o      = out_v_q;
  assign data_o   = out_data_q;

  always_comb begin
    tgt_rdy = 1'b0;
    for (int n = 0; n < num_channels_p; n++) begin
      fifo_v[n] = in_v_q & (in_chan == chan_t'(n));
      if (in_chan == chan_t'(n)) tgt_rdy = fifo_rdy[n];
    end
  end

  for (genvar n = 0; n < num_channels_p; n++) begin : g_ch
    bsg_tnc_chan_fifo #(.width_p(payload_width_p), .els_p(fifo_depth_p)) u_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (fifo_v[n]),
      .ready_o   (fifo_rdy[n]),
      .data_i    (in_pay),
      .v_o       (core_v_o[n]),
      .ready_i   (core_ready_i[n]),
      .data_o    (core_data_o[n*payload_width_p +: payload_width_p]),
      .full_o    (fifo_full[n]),
      .empty_o   (fifo_empty[n])
    );
  end

  // Round-robin search starts one past the last winner and wraps.
  always_comb begin
    int j;
    grant_v = 1'b0;
    grant_j = 0;
    for (int i = 1; i <= num_channels_p; i++) begin
      j = int'(last_q) + i;
      if (j >= num_channels_p) j = j - num_channels_p;
      if (!grant_v && core_v_i[j]) begin
        grant_v = 1'b1;
        grant_j = j;
      end
    end
    grant_idx = chan_t'(grant_j);
    for (int n = 0; n < num_channels_p; n++) core_yumi_o[n] = gnt & (grant_j == n);
    out_pkt = '0;
    out_pkt[id_msb_lp -: id_width_gp] = id_width_gp'(client_id_p);
    out_pkt[chan_msb_lp -: cw_lp]     = grant_idx;
    out_pkt[pay_msb_lp:0]             = core_data_i[grant_j*payload_width_p +: payload_width_p];
  end

  always_comb begin
    in_v_d     = in_v_q;
    in_data_d  = in_data_q;
    out_v_d    = out_v_q;
    out_data_d = out_data_q;
    last_d     = last_q;
    if (v_i & ready_o) begin
      in_v_d    = 1'b1;
      in_data_d = data_i;
    end else if (dispatch) begin
      in_v_d = 1'b0;
    end
    if (loadable) out_v_d = gnt;
    if (gnt) begin
      out_data_d = out_pkt;
      last_d     = grant_idx;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      in_v_q     <= 1'b0;
      in_data_q  <= '0;
      out_v_q    <= 1'b0;
      out_data_q <= '0;
      last_q     <= chan_t'(num_channels_p - 1);
    end else begin
      in_v_q     <= in_v_d;
      in_data_q  <= in_data_d;
      out_v_q    <= out_v_d;
      out_data_q <= out_data_d;
      last_q     <= last_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{fifo_full, fifo_empty, in_data_q};

`ifdef BSG_TNC_MC_STATS_EN
  logic [31:0] stat_in_q, stat_in_d, stat_out_q, stat_out_d;
  logic [15:0] stat_drop_q, stat_drop_d;

  always_comb begin
    stat_in_d   = stat_in_q;
    stat_out_d  = stat_out_q;
    stat_drop_d = stat_drop_q;
    if (v_i & ready_o & ~&stat_in_q)    stat_in_d   = stat_in_q + 1'b1;
    if (out_v_q & yumi_i & ~&stat_out_q) stat_out_d  = stat_out_q + 1'b1;
    if (drop & ~&stat_drop_q)            stat_drop_d = stat_drop_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stat_in_q   <= '0;
      stat_out_q  <= '0;
      stat_drop_q <= '0;
    end else begin
      stat_in_q   <= stat_in_d;
      stat_out_q  <= stat_out_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign stat_in_o   = stat_in_q;
  assign stat_out_o  = stat_out_q;
  assign stat_drop_o = stat_drop_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_bsg_test_node_client_mc.sv
// Directed bench: default 2-channel client plus a 3-channel instance for the
// out-of-range drop case.
module tb_bsg_test_node_client_mc;

  logic         clk = 1'b0;
  logic         rst_n, en;
  logic         v_i, rdy, v_o, yumi;
  logic [79:0]  din, dout;
  logic [1:0]   cv, crdy, cvi, cyumi;
  logic [127:0] cdo, cdi;
  logic         v3, rdy3, v_o3, yumi3;
  logic [79:0]  din3, dout3;
  logic [2:0]   cv3, crdy3, cvi3, cyumi3;
  logic [191:0] cdo3, cdi3;
`ifdef BSG_TNC_MC_STATS_EN
  logic [31:0]  s_in, s_out, s_in3, s_out3;
  logic [15:0]  s_drop, s_drop3;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bsg_test_node_client_mc dut (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .v_i(v_i), .data_i(din), .ready_o(rdy),
    .v_o(v_o), .data_o(dout), .yumi_i(yumi), .core_v_o(cv), .core_data_o(cdo),
    .core_ready_i(crdy), .core_v_i(cvi), .core_data_i(cdi),
`ifdef BSG_TNC_MC_STATS_EN
    .stat_in_o(s_in), .stat_out_o(s_out), .stat_drop_o(s_drop),
`endif
    .core_yumi_o(cyumi));

  bsg_test_node_client_mc #(.num_channels_p(3)) dut3 (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .v_i(v3), .data_i(din3), .ready_o(rdy3),
    .v_o(v_o3), .data_o(dout3), .yumi_i(yumi3), .core_v_o(cv3), .core_data_o(cdo3),
    .core_ready_i(crdy3), .core_v_i(cvi3), .core_data_i(cdi3),
`ifdef BSG_TNC_MC_STATS_EN
    .stat_in_o(s_in3), .stat_out_o(s_out3), .stat_drop_o(s_drop3),
`endif
    .core_yumi_o(cyumi3));

  typedef struct {
    logic        v;
    int          ch;
    logic [63:0] pay;
    logic [1:0]  crdy;
    logic        erdy;
    logic [1:0]  ecv;
    logic        c0;
    logic [63:0] d0;
    logic        c1;
    logic [63:0] d1;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [79:0] mkpkt(input int c, input logic [63:0] p, input int cw);
    logic [79:0] r;
    int cc;
    cc = c;
    r = '0;
    if (cw == 1) r[75] = cc[0];
    else begin
      r[75] = cc[1];
      r[74] = cc[0];
    end
    r[63:0] = p;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; v_i = 1'b0; din = '0; yumi = 1'b0; crdy = '0; cvi = 2'b11; cdi = '0;
    v3 = 1'b0; din3 = '0; yumi3 = 1'b0; crdy3 = '0; cvi3 = '0; cdi3 = '0;

    // backpressure table: core 0 stalls, its FIFO fills, in_r holds, chan 1 waits behind
    tbl[0]  = '{1'b1, 1, 64'hDEADBEEF, 2'b11, 1'b1, 2'b00, 1'b0, 64'h0,  1'b0, 64'h0};
    tbl[1]  = '{1'b0, 0, 64'h0,        2'b11, 1'b1, 2'b00, 1'b0, 64'h0,  1'b0, 64'h0};
    tbl[2]  = '{1'b0, 0, 64'h0,        2'b11, 1'b1, 2'b10, 1'b0, 64'h0,  1'b1, 64'hDEADBEEF};
    tbl[3]  = '{1'b0, 0, 64'h0,        2'b11, 1'b1, 2'b00, 1'b0, 64'h0,  1'b0, 64'h0};
    tbl[4]  = '{1'b1, 0, 64'hA0,       2'b10, 1'b1, 2'b00, 1'b0, 64'h0,  1'b0, 64'h0};
    tbl[5]  = '{1'b1, 0, 64'hB0,       2'b10, 1'b1, 2'b00, 1'b0, 64'h0,  1'b0, 64'h0};
    tbl[6]  = '{1'b1, 0, 64'hC0,       2'b10, 1'b1, 2'b01, 1'b1, 64'hA0, 1'b0, 64'h0};
    tbl[7]  = '{1'b1, 0, 64'hD0,       2'b10, 1'b0, 2'b01, 1'b1, 64'hA0, 1'b0, 64'h0};
    tbl[8]  = '{1'b1, 0, 64'hD0,       2'b11, 1'b0, 2'b01, 1'b1, 64'hA0, 1'b0, 64'h0};
    tbl[9]  = '{1'b1, 0, 64'hD0,       2'b11, 1'b1, 2'b01, 1'b1, 64'hB0, 1'b0, 64'h0};
    tbl[10] = '{1'b1, 1, 64'h1111,     2'b11, 1'b1, 2'b01, 1'b1, 64'hC0, 1'b0, 64'h0};
    tbl[11] = '{1'b0, 0, 64'h0,        2'b11, 1'b1, 2'b01, 1'b1, 64'hD0, 1'b0, 64'h0};
    tbl[12] = '{1'b0, 0, 64'h0,        2'b11, 1'b1, 2'b10, 1'b0, 64'h0,  1'b1, 64'h1111};
    tbl[13] = '{1'b0, 0, 64'h0,        2'b11, 1'b1, 2'b00, 1'b0, 64'h0,  1'b0, 64'h0};

    #2;
    chk("rst_ready", rdy, 0);
    chk("rst_v_o", v_o, 0);
    chk("rst_data_o", dout, 0);
    chk("rst_core_v", cv, 0);
    chk("rst_core_yumi", cyumi, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; cvi = 2'b00;

    for (int i = 0; i < 14; i++) begin
      v_i = tbl[i].v; din = mkpkt(tbl[i].ch, tbl[i].pay, 1); crdy = tbl[i].crdy;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), rdy, tbl[i].erdy);
      chk($sformatf("vec%0d_core_v", i), cv, tbl[i].ecv);
      if (tbl[i].c0) chk($sformatf("vec%0d_data0", i), cdo[63:0], tbl[i].d0);
      if (tbl[i].c1) chk($sformatf("vec%0d_data1", i), cdo[127:64], tbl[i].d1);
      nxt();
    end
    v_i = 1'b0;
`ifdef BSG_TNC_MC_STATS_EN
    chk("stat_in", s_in, 6);
`endif

    // arbitration with both cores requesting and the ring always consuming
    cvi = 2'b11; cdi = {64'h200, 64'h100}; yumi = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_yumi", k), cyumi, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) begin
        chk($sformatf("rr%0d_v_o", k), v_o, 1);
        chk($sformatf("rr%0d_data", k), dout,
            (k % 2 == 1) ? mkpkt(0, 64'h100, 1) : mkpkt(1, 64'h200, 1));
      end
      nxt();
    end

    // ring stalls: output held, no grants
    yumi = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_yumi", k), cyumi, 0);
      chk($sformatf("stall%0d_data", k), dout, mkpkt(1, 64'h200, 1));
      nxt();
    end
    yumi = 1'b1;
    @(negedge clk);
    chk("reload_yumi", cyumi, 2'b01);
    chk("reload_v_o", v_o, 1);
    nxt();
    yumi = 1'b0; cvi = 2'b00;
    @(negedge clk);
    chk("reload_data", dout, mkpkt(0, 64'h100, 1));
    chk("reload_yumi_idle", cyumi, 0);
    nxt();
    yumi = 1'b1;
    nxt();
    yumi = 1'b0;
    @(negedge clk);
    chk("drain_v_o", v_o, 0);
`ifdef BSG_TNC_MC_STATS_EN
    chk("stat_out", s_out, 5);
`endif
    nxt();

    // 3-channel instance: chan 3 is dropped, chan 2 still delivered
    v3 = 1'b1; din3 = mkpkt(3, 64'h33, 2); crdy3 = 3'b111;
    @(negedge clk);
    chk("drop_ready0", rdy3, 1);
    nxt();
    din3 = mkpkt(2, 64'h22, 2);
    @(negedge clk);
    chk("drop_ready1", rdy3, 1);
    chk("drop_core_v1", cv3, 0);
    nxt();
    v3 = 1'b0;
    @(negedge clk);
    chk("drop_core_v2", cv3, 0);
    nxt();
    @(negedge clk);
    chk("ch2_core_v", cv3, 3'b100);
    chk("ch2_data", cdo3[191:128], 64'h22);
`ifdef BSG_TNC_MC_STATS_EN
    chk("stat_drop3", s_drop3, 1);
    chk("stat_in3", s_in3, 2);
    chk("stat_out3", s_out3, 0);
`endif
    nxt();

    // asynchronous reset with FIFO and output register occupied
    cvi = 2'b01; cdi = {64'h88, 64'h77}; crdy = 2'b00;
    v_i = 1'b1; din = mkpkt(0, 64'hE1, 1);
    nxt();
    din = mkpkt(0, 64'hE2, 1);
    nxt();
    v_i = 1'b0;
    nxt();
    @(negedge clk);
    chk("pre_rst_v_o", v_o, 1);
    chk("pre_rst_core_v", cv, 2'b01);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ready", rdy, 0);
    chk("arst_v_o", v_o, 0);
    chk("arst_data_o", dout, 0);
    chk("arst_core_v", cv, 0);
    chk("arst_core_yumi", cyumi, 0);
    nxt();
    rst_n = 1'b1; cvi = 2'b11;
    @(negedge clk);
    chk("post_rst_ready", rdy, 1);
    chk("post_rst_core_v", cv, 0);
    chk("post_rst_yumi", cyumi, 2'b01);
    nxt();
    cvi = 2'b00;
    @(negedge clk);
    chk("post_rst_v_o", v_o, 1);
    chk("post_rst_data", dout, mkpkt(0, 64'h77, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_test_node_client_mc.md
Name: bsg_test_node_client_mc

Overview:
Multi-channel, parametrised test-node client for the bsg test ring. It accepts ring packets, strips the header and dispatches each payload by channel field into per-channel FIFOs that feed num_channels_p external cores. It collects core results through a round-robin arbiter and returns them as ring packets tagged with client id and channel. It replaces the single-core, fixed-75-bit client.

Parameters:
ring_width_p, 80, ring packet width; must be >= 4 + chan_width_lp + payload_width_p
payload_width_p, 64, core data width
num_channels_p, 2, number of attached cores, 1..16
fifo_depth_p, 2, entries per channel input FIFO, >= 1
client_id_p, 0, 4-bit id placed in the top nibble of every outbound packet

Ports:
clk_i  in  1  single clock; all state on rising edge
reset_n_i  in  1  asynchronous active-low reset
en_i  in  1  enables acceptance of new ring packets
v_i  in  1  ring packet valid
data_i  in  ring_width_p  ring packet
ready_o  out  1  client can accept data_i
v_o  out  1  outbound packet valid
data_o  out  ring_width_p  outbound packet
yumi_i  in  1  ring consumes data_o this cycle
core_v_o  out  num_channels_p  per-channel payload valid
core_data_o  out  num_channels_p*payload_width_p  per-channel payload; channel n at [n*payload_width_p +: payload_width_p]
core_ready_i  in  num_channels_p  core n accepts payload (transfer = v & ready)
core_v_i  in  num_channels_p  core n has a result
core_data_i  in  num_channels_p*payload_width_p  core results, same packing
core_yumi_o  out  num_channels_p  one-hot; result taken from core n

Behaviour:
- Packet format: [ring_width_p-1 -: 4] = id; next chan_width_lp = max(1, clog2(num_channels_p)) bits = channel; [payload_width_p-1:0] = payload; remaining bits zero. Inbound id is ignored.
- Input stage: one-entry register in_r.
  - ready_o = en_i & (~in_v_r | dispatch). It does not depend on data_i.
  - Handshake is v_i & ready_o. Data is captured into in_r.
- Dispatch: when in_v_r is set, the register targets FIFO[chan].
  - If that FIFO is not full, the entry is enqueued and in_r is freed in the same cycle.
  - If that FIFO is full, in_r holds. This blocks all channels (head-of-line is accepted behaviour).
  - If chan >= num_channels_p, the packet is dropped in the dispatch cycle.
- Channel FIFO: registered, depth fifo_depth_p. core_v_o[n] = ~empty. Data is the head entry. Dequeue on core_v_o & core_ready_i.
  - Enqueue is allowed only when not full. A simultaneous dequeue does not free a full slot that cycle.
  - Enqueue into an empty FIFO and dequeue of the same entry cannot occur in one cycle.
- Latency: handshake at cycle t gives in_v_r at t+1, enqueue at t+1, and core_v_o at t+2 (minimum).
- Output stage: one-entry register out_r. v_o = out_v_r.
  - data_o = {client_id_p[3:0], chan, zero pad, payload}.
  - The register is loadable when ~out_v_r | yumi_i.
  - When loadable, the round-robin arbiter grants the lowest-index requesting core_v_i, starting from last_grant+1 and wrapping.
  - core_yumi_o[grant] is asserted in that cycle only. Load occurs on the next edge, so result-to-v_o latency is 1.
  - last_grant updates only on a grant.
- en_i low: ready_o = 0. Dispatch, FIFOs, cores and output continue to drain.
- Reset values (asynchronous, while reset_n_i = 0):
  - ready_o = 0, v_o = 0, data_o = 0, core_v_o = 0, core_yumi_o = 0.
  - FIFOs empty. last_grant = num_channels_p-1, so channel 0 has first priority.
- Reset mid-operation discards all in-flight packets. After release, ready_o = en_i in the first cycle.

Optional Feature:
- Macro BSG_TNC_MC_STATS_EN.
- When defined, adds output ports stat_in_o[31:0], stat_out_o[31:0] and stat_drop_o[15:0]. These count accepted input handshakes, yumi_i handshakes, and dropped out-of-range packets.
- The counters saturate at all-ones and reset to 0.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package bsg_tnc_pkg holds:
  - localparam id_width_gp = 4.
  - function chan_width(num_channels), returning max(1, clog2(n)).
  - Field-offset functions for id, chan and payload.
- Sub-module bsg_tnc_chan_fifo, parameters width_p and els_p, with v/ready input, v/ready output, full and empty. It is instantiated num_channels_p times via generate.
- The arbiter stays inline.

Test Plan:
- Defaults; send payload 0xDEAD_BEEF on chan 1 at t with core_ready_i = 2'b11 -> core_v_o[1] = 1 at t+2, core_data_o[127:64] = 0xDEADBEEF, core_v_o[0] = 0.
- core_ready_i[0] = 0; send 4 packets to chan 0 -> 2 fill the FIFO and 1 holds in in_r; ready_o drops to 0; a following chan-1 packet waits until core_ready_i[0] = 1.
- core_v_i = 2'b11 held, yumi_i = 1 constant -> core_yumi_o sequence 01, 10, 01, 10; data_o[79:76] = 0 and the chan field alternates.
- yumi_i = 0 with v_o = 1 for 5 cycles -> data_o stable, no core_yumi_o pulses; yumi_i = 1 -> reload in the same cycle.
- num_channels_p = 3, chan = 3 -> packet dropped, no core_v_o; with BSG_TNC_MC_STATS_EN, stat_drop_o = 1 and stat_in_o = 1.
- reset_n_i asserted with FIFOs non-empty and v_o = 1 -> outputs 0 immediately (asynchronous); after release, channel 0 wins the first arbitration against 2'b11 requests.
